verificar_pin: RTL and testbench
================================

Name: verificar_pin

Overview:
- Downstream consumer of the PIN-assembly stage.
- Takes the assembled PIN packet (`pinPac_t`) and compares each submitted PIN against a stored master PIN.
- Drives the lock actuator and user-feedback pulses, counts consecutive failures, and enforces a timed lockout.
- Supports reprogramming the master PIN while the lock is open.

Parameters:
- DEFAULT_PIN, 16'h1234, master PIN loaded at reset; digit1 is in bits [15:12], digit4 in bits [3:0].
- MAX_TRIES, 3, number of consecutive wrong submissions that triggers lockout (≥1).
- UNLOCK_CYCLES, 50_000_000, clock cycles the lock stays open after a correct PIN (≥2).
- LOCKOUT_CYCLES, 500_000_000, clock cycles submissions are ignored after MAX_TRIES failures (≥2).
- DIGIT_BLANK, 4'hA, code marking an empty digit position.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; asserted when rst=0.
- pin_in  input  17 (`pinPac_t`)  assembled PIN; pin_in.status is a 1-cycle submit pulse; digit1..digit4 are valid in that cycle.
- prog_req  input  1  level; when high during a submit in UNLOCKED, the submitted PIN becomes the new master.
- lock_now  input  1  level; forces UNLOCKED back to IDLE (door-closed sensor).
- unlock  output  1  lock actuator, high while in UNLOCKED.
- lockout  output  1  high while in LOCKED_OUT.
- ok_pulse  output  1  1-cycle pulse on an accepted PIN.
- fail_pulse  output  1  1-cycle pulse on a rejected PIN.
- prog_ok  output  1  1-cycle pulse when the master PIN is updated.
- tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts before lockout.

Behaviour:
- Async reset (rst=0):
  - state=IDLE; master=DEFAULT_PIN; fail count=0; timer=0.
  - unlock=0, lockout=0, ok_pulse=0, fail_pulse=0, prog_ok=0, tries_left=MAX_TRIES.
- Submit: pin_in.status=1 sampled at a rising edge. All responses appear at the next edge (latency 1); all outputs are registered.
- Validity: a submitted PIN containing any digit equal to DIGIT_BLANK is incomplete. An incomplete PIN is treated as wrong in IDLE and rejected for programming.
- Match: all four digits equal the corresponding master digits.
- State IDLE:
  - Submit and match → UNLOCKED; ok_pulse=1; fail count cleared; timer loaded with UNLOCK_CYCLES-1.
  - Submit and no match → fail_pulse=1; fail count +1.
  - If the new fail count equals MAX_TRIES → LOCKED_OUT; timer loaded with LOCKOUT_CYCLES-1.
- State UNLOCKED:
  - unlock=1; timer decrements each cycle.
  - Timer reaching 0, or lock_now=1 → IDLE at the next edge.
  - Submit with prog_req=1 and a valid PIN → master updated; prog_ok=1; timer reloaded; stays UNLOCKED.
  - Submit with prog_req=1 and an invalid PIN → fail_pulse=1; master unchanged; fail count unchanged.
  - Submit with prog_req=0 → ignored (no pulses).
- State LOCKED_OUT:
  - lockout=1; all submits ignored (no pulses, no count change).
  - Timer reaching 0 → IDLE with fail count=0.
- Simultaneous events:
  - lock_now and a submit in the same cycle in UNLOCKED: lock_now wins, submit ignored, master unchanged.
  - Timer expiry and a submit in the same cycle: expiry wins, submit ignored.
- tries_left = MAX_TRIES - fail count. It reads 0 during LOCKED_OUT.
- Pulses never last more than one cycle, even if pin_in.status is held high. Only the rising edge of status counts as a submit; a registered copy of status is kept.
- Reset mid-UNLOCKED or mid-LOCKED_OUT returns to IDLE immediately (asynchronously) and restores DEFAULT_PIN.

Test Plan (MAX_TRIES=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, DEFAULT_PIN=16'h1234):
1. Reset, then submit 1,2,3,4 → next cycle ok_pulse=1 and unlock=1. unlock stays high exactly 8 cycles, then 0; tries_left=3.
2. Submit 1,2,3,5 three times → fail_pulse after each; tries_left 2,1,0. After the third, lockout=1 for 16 cycles. A correct submit during lockout gives no pulse. Afterwards tries_left=3.
3. Submit A,1,2,3 (blank digit) in IDLE → fail_pulse=1; tries_left=2.
4. Unlock with 1234, then submit 9,8,7,6 with prog_req=1 → prog_ok=1. After expiry, 1234 → fail_pulse; 9876 → ok_pulse.
5. Unlock, pulse lock_now at cycle 3 together with a prog submit of 5555 → unlock=0 next cycle; no prog_ok; master still 1234.
6. Hold pin_in.status high for 5 cycles with 1234 → exactly one ok_pulse. Assert rst=0 mid-unlock → unlock=0 immediately; tries_left=3.

Source files
------------

// File: rtl/verificar_pin_if.sv
// Bus between the PIN-assembly stage and the verifier: packet in, lock/feedback out.
// pin_in packing: [16] status, [15:12] digit1, [11:8] digit2, [7:4] digit3, [3:0] digit4.
interface verificar_pin_if #(
  parameter int unsigned MAX_TRIES = 3
);
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

  logic [16:0]       pin_in;
  logic              prog_req;
  logic              lock_now;
  logic              unlock;
  logic              lockout;
  logic              ok_pulse;
  logic              fail_pulse;
  logic              prog_ok;
  logic [TriesW-1:0] tries_left;

  modport master (
    output pin_in, prog_req, lock_now,
    input  unlock, lockout, ok_pulse, fail_pulse, prog_ok, tries_left
  );

  modport slave (
    input  pin_in, prog_req, lock_now,
    output unlock, lockout, ok_pulse, fail_pulse, prog_ok, tries_left
  );
endinterface

// File: rtl/verificar_pin.sv
// PIN verifier: matches submitted PINs against a programmable master, drives the lock,
// counts consecutive failures and enforces a timed lockout.
module verificar_pin #(
  parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter logic [3:0]  DIGIT_BLANK    = 4'hA
) (
  input logic clk,
  input logic rst,
  verificar_pin_if.slave bus
);

  localparam int unsigned TriesW    = $clog2(MAX_TRIES + 1);
  localparam int unsigned MaxCycles = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles);

  localparam logic [TimerW-1:0] UnlockLoad  = TimerW'(UNLOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);
  localparam logic [TriesW-1:0] TriesFull   = TriesW'(MAX_TRIES);

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef enum logic [1:0] {StIdle, StUnlocked, StLockedOut} state_e;

  state_e            state_q, state_d;
  logic [15:0]       master_q, master_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [TriesW-1:0] tries_q, tries_d;
  logic              status_q;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic              prog_q, prog_d;
  logic              unlock_q, unlock_d;
  logic              lockout_q, lockout_d;

  pinPac_t     pin;
  logic [15:0] pin_digits;
  logic        pin_valid;
  logic        pin_match;
  logic        submit;

  assign pin        = pinPac_t'(bus.pin_in);
  assign pin_digits = {pin.digit1, pin.digit2, pin.digit3, pin.digit4};
  assign pin_valid  = (pin.digit1 != DIGIT_BLANK) && (pin.digit2 != DIGIT_BLANK) &&
                      (pin.digit3 != DIGIT_BLANK) && (pin.digit4 != DIGIT_BLANK);
  assign pin_match  = (pin_digits == master_q);
  // Only the rising edge of status is a submit, so a held status yields one response.
  assign submit     = pin.status & ~status_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    timer_d  = timer_q;
    tries_d  = tries_q;
    ok_d     = 1'b0;
    fail_d   = 1'b0;
    prog_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (submit) begin
          if (pin_valid && pin_match) begin
            state_d = StUnlocked;
            ok_d    = 1'b1;
            tries_d = TriesFull;
            timer_d = UnlockLoad;
          end else begin
            fail_d  = 1'b1;
            tries_d = tries_q - TriesW'(1);
            if (tries_q == TriesW'(1)) begin
              state_d = StLockedOut;
              timer_d = LockoutLoad;
            end
          end
        end
      end
      StUnlocked: begin
        // Door closing and timer expiry both take priority over any submit.
        if (bus.lock_now || (timer_q == '0)) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TimerW'(1);
          if (submit && bus.prog_req) begin
            if (pin_valid) begin
              master_d = pin_digits;
              prog_d   = 1'b1;
              timer_d  = UnlockLoad;
            end else begin
              fail_d = 1'b1;
            end
          end
        end
      end
      StLockedOut: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          tries_d = TriesFull;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unlock_d  = (state_d == StUnlocked);
    lockout_d = (state_d == StLockedOut);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      master_q  <= DEFAULT_PIN;
      timer_q   <= '0;
      tries_q   <= TriesFull;
      status_q  <= 1'b0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
      prog_q    <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      master_q  <= master_d;
      timer_q   <= timer_d;
      tries_q   <= tries_d;
      status_q  <= pin.status;
      ok_q      <= ok_d;
      fail_q    <= fail_d;
      prog_q    <= prog_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
    end
  end

  assign bus.unlock     = unlock_q;
  assign bus.lockout    = lockout_q;
  assign bus.ok_pulse   = ok_q;
  assign bus.fail_pulse = fail_q;
  assign bus.prog_ok    = prog_q;
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_verificar_pin.sv
// Directed bench for verificar_pin with short timers (unlock 8, lockout 16, 3 tries).
module tb_verificar_pin;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic       s_ok, s_fail, s_prog, s_unlock, s_lockout;
  logic [1:0] s_tries;
  int         n;

  verificar_pin_if #(.MAX_TRIES(3)) bus ();

  verificar_pin #(
    .DEFAULT_PIN   (16'h1234),
    .MAX_TRIES     (3),
    .UNLOCK_CYCLES (8),
    .LOCKOUT_CYCLES(16),
    .DIGIT_BLANK   (4'hA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-edge submit; the response seen after that edge is snapshotted, then status drops.
  task automatic submit(input logic [15:0] pin, input logic prog, input logic lk);
    bus.pin_in   = {1'b1, pin};
    bus.prog_req = prog;
    bus.lock_now = lk;
    tick();
    s_ok      = bus.ok_pulse;
    s_fail    = bus.fail_pulse;
    s_prog    = bus.prog_ok;
    s_unlock  = bus.unlock;
    s_lockout = bus.lockout;
    s_tries   = bus.tries_left;
    bus.pin_in   = {1'b0, pin};
    bus.prog_req = 1'b0;
    bus.lock_now = 1'b0;
    tick();
  endtask

  // Adds further cycles with unlock high to a running count; bounded.
  task automatic count_unlock(input int start, output int cnt);
    cnt = start;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.unlock) cnt++;
      else break;
    end
  endtask

  task automatic close_door();
    bus.lock_now = 1'b1;
    tick();
    bus.lock_now = 1'b0;
    chk("door_closed", 32'(bus.unlock), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.pin_in   = '0;
    bus.prog_req = 1'b0;
    bus.lock_now = 1'b0;
    #12;
    chk("rst_unlock", 32'(bus.unlock), 32'd0);
    chk("rst_lockout", 32'(bus.lockout), 32'd0);
    chk("rst_ok", 32'(bus.ok_pulse), 32'd0);
    chk("rst_fail", 32'(bus.fail_pulse), 32'd0);
    chk("rst_prog", 32'(bus.prog_ok), 32'd0);
    chk("rst_tries", 32'(bus.tries_left), 32'd3);
    rst = 1'b1;
    tick();

    // 1: correct PIN opens for exactly 8 cycles
    submit(16'h1234, 1'b0, 1'b0);
    chk("t1_ok", 32'(s_ok), 32'd1);
    chk("t1_unlock", 32'(s_unlock), 32'd1);
    chk("t1_ok_one_cycle", 32'(bus.ok_pulse), 32'd0);
    count_unlock(32'(s_unlock) + 32'(bus.unlock), n);
    chk("t1_unlock_len", 32'(n), 32'd8);
    chk("t1_tries", 32'(bus.tries_left), 32'd3);

    // 2: three failures then lockout for 16 cycles
    submit(16'h1235, 1'b0, 1'b0);
    chk("t2_fail1", 32'(s_fail), 32'd1);
    chk("t2_tries1", 32'(s_tries), 32'd2);
    submit(16'h1235, 1'b0, 1'b0);
    chk("t2_fail2", 32'(s_fail), 32'd1);
    chk("t2_tries2", 32'(s_tries), 32'd1);
    submit(16'h1235, 1'b0, 1'b0);
    chk("t2_fail3", 32'(s_fail), 32'd1);
    chk("t2_tries3", 32'(s_tries), 32'd0);
    chk("t2_lockout", 32'(s_lockout), 32'd1);
    n = 32'(s_lockout) + 32'(bus.lockout);
    submit(16'h1234, 1'b0, 1'b0);
    chk("t2_no_ok_locked", 32'(s_ok), 32'd0);
    chk("t2_no_unlock_locked", 32'(s_unlock), 32'd0);
    n = n + 32'(s_lockout) + 32'(bus.lockout);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.lockout) n++;
      else break;
    end
    chk("t2_lockout_len", 32'(n), 32'd16);
    chk("t2_tries_after", 32'(bus.tries_left), 32'd3);

    // 3: blank digit is a failure
    submit(16'hA123, 1'b0, 1'b0);
    chk("t3_fail", 32'(s_fail), 32'd1);
    chk("t3_tries", 32'(s_tries), 32'd2);

    // 4: reprogram to 9876, timer reload, then only 9876 opens
    submit(16'h1234, 1'b0, 1'b0);
    chk("t4_ok", 32'(s_ok), 32'd1);
    chk("t4_tries_clear", 32'(s_tries), 32'd3);
    submit(16'h9876, 1'b1, 1'b0);
    chk("t4_prog_ok", 32'(s_prog), 32'd1);
    chk("t4_prog_no_fail", 32'(s_fail), 32'd0);
    count_unlock(32'(s_unlock) + 32'(bus.unlock), n);
    chk("t4_reload_len", 32'(n), 32'd8);
    submit(16'h1234, 1'b0, 1'b0);
    chk("t4_old_fail", 32'(s_fail), 32'd1);
    chk("t4_old_no_ok", 32'(s_ok), 32'd0);
    submit(16'h9876, 1'b0, 1'b0);
    chk("t4_new_ok", 32'(s_ok), 32'd1);
    submit(16'h1234, 1'b1, 1'b0);
    chk("t4_restore_prog", 32'(s_prog), 32'd1);
    close_door();

    // 5: lock_now beats a simultaneous programming submit
    submit(16'h1234, 1'b0, 1'b0);
    chk("t5_ok", 32'(s_ok), 32'd1);
    submit(16'h5555, 1'b1, 1'b1);
    chk("t5_unlock_off", 32'(s_unlock), 32'd0);
    chk("t5_no_prog", 32'(s_prog), 32'd0);
    submit(16'h5555, 1'b0, 1'b0);
    chk("t5_5555_fail", 32'(s_fail), 32'd1);
    submit(16'h1234, 1'b0, 1'b0);
    chk("t5_master_kept", 32'(s_ok), 32'd1);
    close_door();

    // 6: held status gives one pulse; async reset restores the default master
    bus.pin_in = {1'b1, 16'h1234};
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ok_pulse) n++;
    end
    bus.pin_in = {1'b0, 16'h1234};
    tick();
    chk("t6_single_ok", 32'(n), 32'd1);
    chk("t6_unlocked", 32'(bus.unlock), 32'd1);
    submit(16'h4321, 1'b1, 1'b0);
    chk("t6_prog_ok", 32'(s_prog), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_unlock", 32'(bus.unlock), 32'd0);
    chk("t6_async_tries", 32'(bus.tries_left), 32'd3);
    #2 rst = 1'b1;
    tick();
    submit(16'h4321, 1'b0, 1'b0);
    chk("t6_prog_lost", 32'(s_fail), 32'd1);
    submit(16'h1234, 1'b0, 1'b0);
    chk("t6_default_back", 32'(s_ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
